complex_bfly_pipe: RTL and testbench
====================================

Name: complex_bfly_pipe

Overview:
- Parametrised, pipelined radix-2/radix-4 trivial-twiddle butterfly for the FFT datapath.
- Replaces the separate combinational complex add, subtract and multiply-by-i helpers with one unit.
- Adds per-transaction scaling, saturation, a sticky overflow flag, a sideband tag and valid/ready flow control.
- Sits between the stage input buffer and the twiddle multiplier or stage output buffer.

Parameters:
- DW, 16: width of each real/imag component, signed two's complement.
- TAG_W, 8: width of the sideband tag carried alongside the data (e.g. sample index).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid_i  in  1  input transaction valid
- in_ready_o  out  1  unit can accept an input this cycle
- op_i  in  2  operation: 00 BFLY, 01 BFLY_J, 10 PASS, 11 reserved (treated as PASS)
- scale_i  in  1  1 = divide results by 2 (arithmetic shift); 0 = saturate to DW
- x_r_i, x_i_i  in  DW each  operand x, real/imag
- y_r_i, y_i_i  in  DW each  operand y, real/imag
- tag_i  in  TAG_W  sideband tag
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts the result
- a_r_o, a_i_o  out  DW each  result a
- b_r_o, b_i_o  out  DW each  result b
- tag_o  out  TAG_W  tag of the current result
- sat_o  out  1  any of the four components of the current result saturated
- ovf_o  out  1  sticky overflow flag
- ovf_clr_i  in  1  clears ovf_o

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values:
  - Both stage-valid bits 0, so out_valid_o=0.
  - a/b outputs, tag_o and sat_o are 0.
  - ovf_o is 0.
  - in_ready_o reads 1 after reset.
- Reset mid-operation: in-flight transactions are dropped with no output.
- Operations, computed in DW+1 bits (sign-extend operands; no intermediate overflow):
  - BFLY: a = x+y, b = x−y.
  - BFLY_J: a = x + j·y, b = x − j·y, where j·y = (−y_i, y_r). So a_r = x_r−y_i, a_i = x_i+y_r, b_r = x_r+y_i, b_i = x_i−y_r.
  - PASS / reserved: a = x, b = y (sign-extended).
- Stage 1: registers the four DW+1 results plus scale, tag and v1.
- Stage 2, per component:
  - scale=1: value >>> 1 (arithmetic shift, floor rounding); never saturates.
  - scale=0: clamp to [−2^(DW−1), 2^(DW−1)−1].
  - sat_o = OR of the four clamp events.
  - Registers outputs and v2.
- Latency: exactly 2 cycles from accept (in_valid_i & in_ready_o) to out_valid_o, when not stalled.
- Throughput: 1 transaction per cycle.
- Flow control:
  - en2 = !v2 | out_ready_i.
  - en1 = !v1 | en2.
  - in_ready_o = en1; this is a combinational path from out_ready_i, which is acceptable.
  - Each stage loads only when its enable is high. A stage with its enable low holds its contents.
  - While out_valid_o & !out_ready_i, all outputs stay stable.
  - Order is preserved; no transaction is lost or duplicated.
  - in_valid_i without in_ready_o is ignored; the source holds the data.
- ovf_o:
  - Set on any cycle in which stage 2 loads a result with a saturation event.
  - Cleared by ovf_clr_i.
  - If set and clear occur in the same cycle, set wins.
- Boundary cases:
  - −(−2^(DW−1)) in BFLY_J is exact in DW+1 bits and is then clamped or scaled.
  - Full pipeline with out_ready_i=1 accepts a new input every cycle.
  - Empty pipeline keeps in_ready_o=1.

Decomposition:
- Package complex_pkg holds:
  - DW default.
  - Op encodings OP_BFLY, OP_BFLY_J, OP_PASS.
  - The min/max saturation constants as functions of DW.
- Sub-module complex_sat_scale: DW+1 input plus scale, giving a DW output and a sat flag. Instantiated four times in stage 2.

Test Plan:
1. BFLY, scale 0, x=(100,−50), y=(30,20) -> a=(130,−30), b=(70,−70), sat_o=0, out_valid_o exactly 2 cycles after accept.
2. BFLY, scale 0, x=(32767,−32768), y=(1,1) -> a=(32767,−32767), b=(32766,−32768), sat_o=1. ovf_o rises and stays 1 until ovf_clr_i.
3. Same operands, scale 1 -> a=(16384,−16384), b=(16383,−16385), sat_o=0, ovf_o unchanged.
4. BFLY_J:
   - x=(10,20), y=(3,4) -> a=(6,23), b=(14,17).
   - x=(0,0), y=(0,−32768), scale 0 -> a_r=32767 (saturated), b_r=−32768, sat_o=1.
5. Backpressure:
   - Stream tags 0..3 back-to-back with out_ready_i low for 3 cycles after the first result appears.
   - Outputs stay stable while stalled; in_ready_o drops after 2 more accepts.
   - Tags emerge 0,1,2,3 with no loss or duplication.
6. Reset and clear:
   - rst_n=0 for one cycle with both stages valid -> next cycle out_valid_o=0, outputs 0, ovf_o=0.
   - ovf_clr_i asserted in the same cycle a saturating result loads -> ovf_o=1.

Source files
------------

// File: rtl/complex_pkg.sv
// Shared constants for the complex butterfly datapath: default width, op encodings and
// saturation limits.
package complex_pkg;

    localparam int unsigned DW_DEFAULT = 16;

    typedef enum logic [1:0] {
        OP_BFLY   = 2'b00,
        OP_BFLY_J = 2'b01,
        OP_PASS   = 2'b10
    } op_e;

    function automatic int sat_max(int unsigned dw);
        return (int'(1) << (dw - 1)) - 1;
    endfunction

    function automatic int sat_min(int unsigned dw);
        return -(int'(1) << (dw - 1));
    endfunction

endpackage

// File: rtl/complex_sat_scale.sv
// Reduces one DW+1 result component to DW bits: halve (never saturates) or clamp with a
// saturation flag.
module complex_sat_scale
    import complex_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic signed [DW:0]   din,
    input  logic                 scale,
    output logic        [DW-1:0] dout,
    output logic                 sat
);

    localparam logic signed [DW:0] MaxVal = (DW + 1)'(sat_max(DW));
    localparam logic signed [DW:0] MinVal = (DW + 1)'(sat_min(DW));

    always_comb begin
        dout = din[DW-1:0];
        sat  = 1'b0;
        if (scale) begin
            // Dropping the LSB of a DW+1 value is an arithmetic shift with floor rounding.
            dout = din[DW:1];
        end else if (din > MaxVal) begin
            dout = MaxVal[DW-1:0];
            sat  = 1'b1;
        end else if (din < MinVal) begin
            dout = MinVal[DW-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/complex_bfly_pipe.sv
// Two-stage radix-2/radix-4 trivial-twiddle butterfly with scaling, saturation, sticky
// overflow, sideband tag and valid/ready flow control.
module complex_bfly_pipe
    import complex_pkg::*;
#(
    parameter int unsigned DW    = DW_DEFAULT,
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       op_i,
    input  logic             scale_i,
    input  logic [DW-1:0]    x_r_i,
    input  logic [DW-1:0]    x_i_i,
    input  logic [DW-1:0]    y_r_i,
    input  logic [DW-1:0]    y_i_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [DW-1:0]    a_r_o,
    output logic [DW-1:0]    a_i_o,
    output logic [DW-1:0]    b_r_o,
    output logic [DW-1:0]    b_i_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             sat_o,
    output logic             ovf_o,
    input  logic             ovf_clr_i
);

    logic signed [DW:0] xr, xi, yr, yi;
    logic signed [DW:0] res [4];

    logic               v1, v2;
    logic               en1, en2;
    logic signed [DW:0] s1_val [4];
    logic               s1_scale;
    logic [TAG_W-1:0]   s1_tag;
    logic [DW-1:0]      s2_val [4];
    logic [3:0]         s2_sat;

    assign xr = {x_r_i[DW-1], x_r_i};
    assign xi = {x_i_i[DW-1], x_i_i};
    assign yr = {y_r_i[DW-1], y_r_i};
    assign yi = {y_i_i[DW-1], y_i_i};

    // Component order in res/s1_val/s2_val: a_r, a_i, b_r, b_i.
    always_comb begin
        res[0] = xr;
        res[1] = xi;
        res[2] = yr;
        res[3] = yi;
        case (op_i)
            OP_BFLY: begin
                res[0] = xr + yr;
                res[1] = xi + yi;
                res[2] = xr - yr;
                res[3] = xi - yi;
            end
            OP_BFLY_J: begin
                res[0] = xr - yi;
                res[1] = xi + yr;
                res[2] = xr + yi;
                res[3] = xi - yr;
            end
            default: ;
        endcase
    end

    assign en2         = !v2 || out_ready_i;
    assign en1         = !v1 || en2;
    assign in_ready_o  = en1;
    assign out_valid_o = v2;

    for (genvar g = 0; g < 4; g++) begin : g_sat
        complex_sat_scale #(
            .DW (DW)
        ) u_sat_scale (
            .din   (s1_val[g]),
            .scale (s1_scale),
            .dout  (s2_val[g]),
            .sat   (s2_sat[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            s1_val   <= '{default: '0};
            s1_scale <= 1'b0;
            s1_tag   <= '0;
            a_r_o    <= '0;
            a_i_o    <= '0;
            b_r_o    <= '0;
            b_i_o    <= '0;
            tag_o    <= '0;
            sat_o    <= 1'b0;
            ovf_o    <= 1'b0;
        end else begin
            if (en1) begin
                v1 <= in_valid_i;
                if (in_valid_i) begin
                    s1_val   <= res;
                    s1_scale <= scale_i;
                    s1_tag   <= tag_i;
                end
            end
            if (en2) begin
                v2 <= v1;
                if (v1) begin
                    a_r_o <= s2_val[0];
                    a_i_o <= s2_val[1];
                    b_r_o <= s2_val[2];
                    b_i_o <= s2_val[3];
                    tag_o <= s1_tag;
                    sat_o <= |s2_sat;
                end
            end
            // A new saturation event outranks a simultaneous clear.
            if (en2 && v1 && (|s2_sat)) begin
                ovf_o <= 1'b1;
            end else if (ovf_clr_i) begin
                ovf_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_complex_bfly_pipe.sv
// Self-checking bench for complex_bfly_pipe: directed cases plus randomized traffic checked
// against an integer reference model.
module tb_complex_bfly_pipe;

    localparam int DW    = 16;
    localparam int TAG_W = 8;
    localparam int VMAX  = 32767;
    localparam int VMIN  = -32768;

    logic             clk;
    logic             rst_n;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [1:0]       op_i;
    logic             scale_i;
    logic [DW-1:0]    x_r_i, x_i_i, y_r_i, y_i_i;
    logic [TAG_W-1:0] tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [DW-1:0]    a_r_o, a_i_o, b_r_o, b_i_o;
    logic [TAG_W-1:0] tag_o;
    logic             sat_o;
    logic             ovf_o;
    logic             ovf_clr_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         ar, ai, br, bi;
        bit         sat;
        logic [7:0] tag;
    } exp_t;

    exp_t exp_q[$];

    complex_bfly_pipe #(
        .DW    (DW),
        .TAG_W (TAG_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .op_i        (op_i),
        .scale_i     (scale_i),
        .x_r_i       (x_r_i),
        .x_i_i       (x_i_i),
        .y_r_i       (y_r_i),
        .y_i_i       (y_i_i),
        .tag_i       (tag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .a_r_o       (a_r_o),
        .a_i_o       (a_i_o),
        .b_r_o       (b_r_o),
        .b_i_o       (b_i_o),
        .tag_o       (tag_o),
        .sat_o       (sat_o),
        .ovf_o       (ovf_o),
        .ovf_clr_i   (ovf_clr_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: exact integer math, then halve (floor) or clamp.
    function automatic int reduce(int v, bit sc);
        if (sc) return (v >= 0) ? v / 2 : -((-v + 1) / 2);
        if (v > VMAX) return VMAX;
        if (v < VMIN) return VMIN;
        return v;
    endfunction

    function automatic bit clipped(int v, bit sc);
        return !sc && (v > VMAX || v < VMIN);
    endfunction

    function automatic exp_t model(int op, bit sc, int xr, int xi, int yr, int yi, int tag);
        exp_t e;
        int   r[4];
        if (op == 0) begin
            r = '{xr + yr, xi + yi, xr - yr, xi - yi};
        end else if (op == 1) begin
            r = '{xr - yi, xi + yr, xr + yi, xi - yr};
        end else begin
            r = '{xr, xi, yr, yi};
        end
        e.ar  = reduce(r[0], sc);
        e.ai  = reduce(r[1], sc);
        e.br  = reduce(r[2], sc);
        e.bi  = reduce(r[3], sc);
        e.sat = clipped(r[0], sc) | clipped(r[1], sc) | clipped(r[2], sc) | clipped(r[3], sc);
        e.tag = 8'(tag);
        return e;
    endfunction

    task automatic drive(int op, bit sc, int xr, int xi, int yr, int yi, int tag);
        op_i    = 2'(op);
        scale_i = sc;
        x_r_i   = 16'(xr);
        x_i_i   = 16'(xi);
        y_r_i   = 16'(yr);
        y_i_i   = 16'(yi);
        tag_i   = 8'(tag);
    endtask

    // Sends one transaction into an empty pipe with out_ready low; lat = cycles from accept
    // to out_valid (accept edge counts as 1), -1 on timeout.
    task automatic run_one(int op, bit sc, int xr, int xi, int yr, int yi, int tag,
                           output int lat);
        out_ready_i = 1'b0;
        drive(op, sc, xr, xi, yr, yi, tag);
        in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        lat = 1;
        while (!out_valid_o && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid_o) lat = -1;
    endtask

    task automatic drain();
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (out_valid_o !== 1'b0 || ovf_o !== 1'b0 || sat_o !== 1'b0 || tag_o !== '0) begin
            errors++;
            $display("FAIL reset_flags: valid=%b ovf=%b sat=%b tag=%0d, want all 0",
                     out_valid_o, ovf_o, sat_o, tag_o);
        end
        checks++;
        if ({a_r_o, a_i_o, b_r_o, b_i_o} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h, want 0", a_r_o, a_i_o, b_r_o, b_i_o);
        end
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", in_ready_o);
        end
    endtask

    task automatic test_bfly();
        int lat;
        run_one(0, 0, 100, -50, 30, 20, 8'h11, lat);
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL bfly_latency: got %0d want 2", lat);
        end
        checks++;
        if (a_r_o !== 16'(130) || a_i_o !== 16'(-30) || b_r_o !== 16'(70) || b_i_o !== 16'(-70)
            || sat_o !== 1'b0 || tag_o !== 8'h11) begin
            errors++;
            $display("FAIL bfly_basic: got a=(%0d,%0d) b=(%0d,%0d) sat=%b tag=%h want (130,-30) (70,-70) 0 11",
                     $signed(a_r_o), $signed(a_i_o), $signed(b_r_o), $signed(b_i_o), sat_o, tag_o);
        end
        drain();
        checks++;
        if (out_valid_o !== 1'b0 || ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL bfly_drain: valid=%b ovf=%b want 0 0", out_valid_o, ovf_o);
        end
    endtask

    task automatic test_saturate();
        int lat;
        run_one(0, 0, 32767, -32768, 1, 1, 8'h22, lat);
        checks++;
        if (a_r_o !== 16'(32767) || a_i_o !== 16'(-32767) || b_r_o !== 16'(32766)
            || b_i_o !== 16'(-32768) || sat_o !== 1'b1 || lat != 2) begin
            errors++;
            $display("FAIL sat_clamp: got a=(%0d,%0d) b=(%0d,%0d) sat=%b lat=%0d want (32767,-32767) (32766,-32768) 1 2",
                     $signed(a_r_o), $signed(a_i_o), $signed(b_r_o), $signed(b_i_o), sat_o, lat);
        end
        checks++;
        if (ovf_o !== 1'b1) begin
            errors++;
            $display("FAIL sat_ovf_set: got %b want 1", ovf_o);
        end
        drain();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ovf_o !== 1'b1) begin
            errors++;
            $display("FAIL sat_ovf_sticky: got %b want 1", ovf_o);
        end
    endtask

    task automatic test_scale();
        int lat;
        run_one(0, 1, 32767, -32768, 1, 1, 8'h33, lat);
        checks++;
        if (a_r_o !== 16'(16384) || a_i_o !== 16'(-16384) || b_r_o !== 16'(16383)
            || b_i_o !== 16'(-16385) || sat_o !== 1'b0) begin
            errors++;
            $display("FAIL scale_half: got a=(%0d,%0d) b=(%0d,%0d) sat=%b want (16384,-16384) (16383,-16385) 0",
                     $signed(a_r_o), $signed(a_i_o), $signed(b_r_o), $signed(b_i_o), sat_o);
        end
        checks++;
        if (ovf_o !== 1'b1) begin
            errors++;
            $display("FAIL scale_ovf_kept: got %b want 1", ovf_o);
        end
        drain();
        ovf_clr_i = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr_i = 1'b0;
        checks++;
        if (ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b want 0", ovf_o);
        end
    endtask

    task automatic test_bfly_j();
        int lat;
        run_one(1, 0, 10, 20, 3, 4, 8'h44, lat);
        checks++;
        if (a_r_o !== 16'(6) || a_i_o !== 16'(23) || b_r_o !== 16'(14) || b_i_o !== 16'(17)
            || sat_o !== 1'b0) begin
            errors++;
            $display("FAIL bflyj_basic: got a=(%0d,%0d) b=(%0d,%0d) sat=%b want (6,23) (14,17) 0",
                     $signed(a_r_o), $signed(a_i_o), $signed(b_r_o), $signed(b_i_o), sat_o);
        end
        drain();
        run_one(1, 0, 0, 0, 0, -32768, 8'h45, lat);
        checks++;
        if (a_r_o !== 16'(32767) || a_i_o !== 16'(0) || b_r_o !== 16'(-32768) || b_i_o !== 16'(0)
            || sat_o !== 1'b1) begin
            errors++;
            $display("FAIL bflyj_negmin: got a=(%0d,%0d) b=(%0d,%0d) sat=%b want (32767,0) (-32768,0) 1",
                     $signed(a_r_o), $signed(a_i_o), $signed(b_r_o), $signed(b_i_o), sat_o);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int         sent = 0, got = 0, stall = 0, cyc = 0;
        bit         seen = 0, prev_stall = 0, accept, deliver;
        logic [DW-1:0]    held_a;
        logic [TAG_W-1:0] held_t;
        out_ready_i = 1'b0;
        while (got < 4 && cyc < 50) begin
            in_valid_i  = (sent < 4);
            drive(0, 0, 10 * sent, 0, 1, 0, sent);
            out_ready_i = seen && stall >= 3;
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (out_valid_o !== 1'b1 || a_r_o !== held_a || tag_o !== held_t) begin
                    errors++;
                    $display("FAIL bp_stable: got v=%b a_r=%h tag=%0d want 1 %h %0d",
                             out_valid_o, a_r_o, tag_o, held_a, held_t);
                end
            end
            if (exp_q.size() == 2 && !out_ready_i) begin
                checks++;
                if (in_ready_o !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_ready_drop: got %b want 0", in_ready_o);
                end
            end
            if (out_valid_o) seen = 1;
            accept  = in_valid_i && in_ready_o;
            deliver = out_valid_o && out_ready_i;
            if (deliver) begin
                checks++;
                if (tag_o !== 8'(got) || a_r_o !== 16'(10 * got + 1)) begin
                    errors++;
                    $display("FAIL bp_order: got tag=%0d a_r=%0d want %0d %0d",
                             tag_o, $signed(a_r_o), got, 10 * got + 1);
                end
                got++;
                void'(exp_q.pop_front());
            end
            if (seen && !out_ready_i) stall++;
            prev_stall = out_valid_o && !out_ready_i;
            held_a     = a_r_o;
            held_t     = tag_o;
            if (accept) begin
                exp_q.push_back(model(0, 0, 10 * sent, 0, 1, 0, sent));
                sent++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        checks++;
        if (got != 4 || sent != 4) begin
            errors++;
            $display("FAIL bp_complete: got %0d sent %0d want 4 4", got, sent);
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        localparam int N = 200;
        int   sent = 0, got = 0, cyc = 0;
        int   op = 0, xr = 0, xi = 0, yr = 0, yi = 0;
        bit   sc = 0, pending = 0, prev_stall = 0, accept, deliver;
        exp_t e;
        logic [4*DW+TAG_W:0] held;
        while ((got < N) && cyc < 4000) begin
            if (!pending && sent < N && $urandom_range(0, 3) != 0) begin
                pending = 1;
                op = int'($urandom_range(0, 3));
                sc = 1'($urandom_range(0, 1));
                xr = ($urandom_range(0, 7) == 0) ? VMIN : int'($urandom_range(0, 65535)) - 32768;
                xi = ($urandom_range(0, 7) == 0) ? VMAX : int'($urandom_range(0, 65535)) - 32768;
                yr = ($urandom_range(0, 7) == 0) ? VMIN : int'($urandom_range(0, 65535)) - 32768;
                yi = ($urandom_range(0, 7) == 0) ? VMIN : int'($urandom_range(0, 65535)) - 32768;
                drive(op, sc, xr, xi, yr, yi, sent);
            end
            in_valid_i  = pending;
            out_ready_i = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (out_valid_o !== 1'b1
                    || {sat_o, tag_o, a_r_o, a_i_o, b_r_o, b_i_o} !== held) begin
                    errors++;
                    $display("FAIL rnd_stable: valid=%b outputs changed during stall", out_valid_o);
                end
            end
            if (exp_q.size() < 2) begin
                checks++;
                if (in_ready_o !== 1'b1) begin
                    errors++;
                    $display("FAIL rnd_ready: got %b want 1 with %0d in flight",
                             in_ready_o, exp_q.size());
                end
            end
            accept  = in_valid_i && in_ready_o;
            deliver = out_valid_o && out_ready_i;
            if (deliver) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_spurious: got tag %0d want no output", tag_o);
                end else begin
                    e = exp_q.pop_front();
                    if (a_r_o !== 16'(e.ar) || a_i_o !== 16'(e.ai) || b_r_o !== 16'(e.br)
                        || b_i_o !== 16'(e.bi) || sat_o !== e.sat || tag_o !== e.tag) begin
                        errors++;
                        $display("FAIL rnd_data: got a=(%0d,%0d) b=(%0d,%0d) sat=%b tag=%0d want (%0d,%0d) (%0d,%0d) %b %0d",
                                 $signed(a_r_o), $signed(a_i_o), $signed(b_r_o), $signed(b_i_o),
                                 sat_o, tag_o, e.ar, e.ai, e.br, e.bi, e.sat, e.tag);
                    end
                end
                got++;
            end
            prev_stall = out_valid_o && !out_ready_i;
            held       = {sat_o, tag_o, a_r_o, a_i_o, b_r_o, b_i_o};
            if (accept) begin
                exp_q.push_back(model(op, sc, xr, xi, yr, yi, sent));
                sent++;
                pending = 0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        checks++;
        if (got != N || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rnd_complete: got %0d left %0d want %0d 0", got, exp_q.size(), N);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_midflight();
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        drive(0, 0, 32767, 0, 5, 0, 8'h66);
        @(posedge clk);
        #1;
        drive(0, 0, 1, 2, 3, 4, 8'h67);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 || ovf_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_full: valid=%b ready=%b ovf=%b want 1 0 1",
                     out_valid_o, in_ready_o, ovf_o);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (out_valid_o !== 1'b0 || ovf_o !== 1'b0 || sat_o !== 1'b0 || tag_o !== '0
            || {a_r_o, a_i_o, b_r_o, b_i_o} !== '0 || in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: valid=%b ovf=%b sat=%b tag=%0d ready=%b want 0 0 0 0 1",
                     out_valid_o, ovf_o, sat_o, tag_o, in_ready_o);
        end
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL mid_dropped: got valid=%b tag=%0d want 0", out_valid_o, tag_o);
            end
        end
        out_ready_i = 1'b0;
    endtask

    task automatic test_clr_collision();
        out_ready_i = 1'b0;
        drive(0, 0, -32768, 0, 0, 0, 8'h77);
        y_r_i      = 16'(1);
        drive(0, 0, -32768, 0, 1, 0, 8'h77);
        in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        ovf_clr_i  = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b1 || sat_o !== 1'b1 || ovf_o !== 1'b1) begin
            errors++;
            $display("FAIL clr_collision: valid=%b sat=%b ovf=%b want 1 1 1",
                     out_valid_o, sat_o, ovf_o);
        end
        drain();
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        ovf_clr_i   = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_bfly();
        test_saturate();
        test_scale();
        test_bfly_j();
        test_backpressure();
        test_random();
        test_reset_midflight();
        test_clr_collision();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
